// File: rtl/logisim_subtractor.sv
// Unsigned subtractor with borrow in/out: result = dataA - dataB - borrowIn.
// Latency: 1 cycle, result and borrowOut are registered.
// No backpressure: a new operation is accepted on every clock edge.
module logisim_subtractor #(
    parameter int nrOfBits     = 32,
    parameter int extendedBits = 33
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                borrowIn,
    input  logic [nrOfBits-1:0] dataA,
    input  logic [nrOfBits-1:0] dataB,
    output logic [nrOfBits-1:0] result,
    output logic                borrowOut
);

    // The extra top bit of the difference is the borrow; any other width
    // would silently truncate or mis-place it, so refuse to elaborate.
    generate
        if (nrOfBits < 1) begin : g_bad_width
            $error("logisim_subtractor: nrOfBits must be at least 1");
        end
        if (extendedBits != nrOfBits + 1) begin : g_bad_ext
            $error("logisim_subtractor: extendedBits must equal nrOfBits+1");
        end
    endgenerate

    logic [extendedBits-1:0] diff;

    // Zero-extended difference; a borrow out of the MSB shows up as a 1 in
    // the top bit because the operands are treated as unsigned.
    always_comb begin
        diff = extendedBits'(dataA) - extendedBits'(dataB) - extendedBits'(borrowIn);
    end

    // Output register; reset wins over the load and drops the in-flight op.
    always_ff @(posedge clk) begin
        if (rst) begin
            result    <= '0;
            borrowOut <= 1'b0;
        end else begin
            result    <= diff[nrOfBits-1:0];
            borrowOut <= diff[extendedBits-1];
        end
    end

endmodule

// File: tb/tb_logisim_subtractor.sv
// Bench for logisim_subtractor: directed boundary cases plus a random stream.
// Outputs are sampled 1 time unit after each rising edge.
// Reference model computes the true signed difference with plain integers.
module tb_logisim_subtractor;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         borrowIn;
    logic [W-1:0] dataA;
    logic [W-1:0] dataB;
    logic [W-1:0] result;
    logic         borrowOut;

    int total = 0;
    int bad   = 0;

    logisim_subtractor #(
        .nrOfBits     (W),
        .extendedBits (W + 1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .borrowIn  (borrowIn),
        .dataA     (dataA),
        .dataB     (dataB),
        .result    (result),
        .borrowOut (borrowOut)
    );

    always #5 clk = ~clk;

    // Reference: true integer difference, borrow = negative, result = mod 2^W.
    function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic bin);
        longint d;
        logic   brw;
        logic [63:0] m;
        d   = longint'({32'h0, a}) - longint'({32'h0, b}) - longint'({63'h0, bin});
        brw = (d < 0);
        if (d < 0) d = d + 64'sh1_0000_0000;
        m = 64'(d);
        return {brw, m[W-1:0]};
    endfunction

    // Drive one triple, let one edge pass, settle just past the edge.
    task automatic step(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
        dataA    = a;
        dataB    = b;
        borrowIn = bin;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(32'hFFFF_FFFF, 32'h0, 1'b0);
        total++;
        if ({borrowOut, result} !== 33'h0) begin
            bad++;
            $display("FAIL reset_value: got bo=%b res=%h, want bo=0 res=00000000", borrowOut, result);
        end
        rst = 1'b0;
        step(32'hFFFF_FFFF, 32'h0, 1'b0);
        total++;
        if ({borrowOut, result} !== {1'b0, 32'hFFFF_FFFF}) begin
            bad++;
            $display("FAIL first_after_reset: got bo=%b res=%h, want bo=0 res=ffffffff", borrowOut, result);
        end
    endtask

    // Directed cases: {a, b, bin} with independently derived expectations.
    task automatic test_directed();
        logic [W-1:0] ta [8];
        logic [W-1:0] tb [8];
        logic         tc [8];
        logic [W:0]   te [8];
        ta[0] = 32'd10;        tb[0] = 32'd3;         tc[0] = 1'b0; te[0] = {1'b0, 32'd7};
        ta[1] = 32'd10;        tb[1] = 32'd3;         tc[1] = 1'b1; te[1] = {1'b0, 32'd6};
        ta[2] = 32'd0;         tb[2] = 32'd1;         tc[2] = 1'b0; te[2] = {1'b1, 32'hFFFF_FFFF};
        ta[3] = 32'd5;         tb[3] = 32'd5;         tc[3] = 1'b1; te[3] = {1'b1, 32'hFFFF_FFFF};
        ta[4] = 32'd5;         tb[4] = 32'd5;         tc[4] = 1'b0; te[4] = {1'b0, 32'h0};
        ta[5] = 32'd0;         tb[5] = 32'hFFFF_FFFF; tc[5] = 1'b1; te[5] = {1'b1, 32'h0};
        ta[6] = 32'h8000_0000; tb[6] = 32'd1;         tc[6] = 1'b0; te[6] = {1'b0, 32'h7FFF_FFFF};
        ta[7] = 32'hFFFF_FFFF; tb[7] = 32'd0;         tc[7] = 1'b0; te[7] = {1'b0, 32'hFFFF_FFFF};
        for (int i = 0; i < 8; i++) begin
            step(ta[i], tb[i], tc[i]);
            total++;
            if ({borrowOut, result} !== te[i]) begin
                bad++;
                $display("FAIL directed_%0d: a=%h b=%h bin=%b got bo=%b res=%h, want bo=%b res=%h",
                         i, ta[i], tb[i], tc[i], borrowOut, result, te[i][W], te[i][W-1:0]);
            end
        end
    endtask

    function automatic logic [W-1:0] rand_operand();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    // One new triple per cycle; an optional one-cycle reset pulse mid-stream.
    task automatic test_stream(input int n, input int rst_at);
        logic [W-1:0] a, b;
        logic         c;
        logic [W:0]   exp;
        logic [W:0]   prev;
        prev = {borrowOut, result};
        for (int i = 0; i < n; i++) begin
            a = rand_operand();
            b = ($urandom_range(0, 5) == 0) ? a : rand_operand();
            c = 1'($urandom_range(0, 1));
            if (i == rst_at) rst = 1'b1;
            dataA    = a;
            dataB    = b;
            borrowIn = c;
            // Registered output must still hold the previous op before the edge.
            @(negedge clk);
            total++;
            if ({borrowOut, result} !== prev) begin
                bad++;
                $display("FAIL stream_hold_%0d: got bo=%b res=%h, want bo=%b res=%h",
                         i, borrowOut, result, prev[W], prev[W-1:0]);
            end
            @(posedge clk);
            #1;
            exp = (i == rst_at) ? '0 : model(a, b, c);
            total++;
            if ({borrowOut, result} !== exp) begin
                bad++;
                $display("FAIL stream_%0d: a=%h b=%h bin=%b rst=%b got bo=%b res=%h, want bo=%b res=%h",
                         i, a, b, c, rst, borrowOut, result, exp[W], exp[W-1:0]);
            end
            rst  = 1'b0;
            prev = exp;
        end
    endtask

    initial begin
        rst      = 1'b1;
        dataA    = '0;
        dataB    = '0;
        borrowIn = 1'b0;
        test_reset();
        test_directed();
        test_stream(1000, -1);
        test_stream(40, 17);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
